vga_rect_fill: RTL and testbench
================================

Name: vga_rect_fill

Overview:
- Memory-mapped rectangle-fill engine sitting directly upstream of the VGA adapter interface's pixel write port.
- The CPU programs corner coordinates and a colour through a small register window, then writes a start command.
- The engine emits one pixel write per clock (x, y, colour, write enable) in raster order until the rectangle is filled.
- Top-level muxes its pixel outputs onto the adapter while oBusy=1; CPU direct pixel writes are used otherwise.

Parameters:
- BASE_ADDR, 32'hFFFF0200, byte address of register 0; window covers BASE_ADDR..BASE_ADDR+0x17.
- H_RES, 320, horizontal pixel count; x clip limit is H_RES-1.
- V_RES, 240, vertical pixel count; y clip limit is V_RES-1.

Ports:
- iCLK  input  1  CPU clock; all state changes on rising edge.
- iRST  input  1  asynchronous active-low reset.
- iMemWrite  input  1  CPU store strobe, sampled on rising iCLK.
- iwMemAddress  input  32  CPU byte address.
- iwMemWriteData  input  32  CPU store data.
- oMemReadData  output  32  combinational read of the addressed register; 0 outside the window.
- oX  output  9  pixel x to adapter.
- oY  output  8  pixel y to adapter.
- oColor  output  8  pixel colour to adapter.
- oWriteEn  output  1  pixel write strobe, one pixel per cycle while high.
- oBusy  output  1  fill in progress.

Behaviour:
- Register map (offset from BASE_ADDR, word aligned; unaligned or out-of-window accesses ignored):
  - 0x00 X0 [8:0]; 0x04 Y0 [7:0]; 0x08 X1 [8:0]; 0x0C Y1 [7:0]; 0x10 COLOR [7:0].
  - 0x14 write CTRL: bit0 START, bit1 ABORT (ABORT wins if both set).
  - 0x14 read STATUS: {29'b0, err, done, busy}.
  - Writes take low bits only; reads zero-extend.
- Reset (async, iRST=0):
  - All registers 0; state IDLE.
  - oX=0, oY=0, oColor=0, oWriteEn=0, oBusy=0; done=0, err=0.
  - Asserting reset mid-fill aborts immediately; no further pixel writes.
- State machine: IDLE, FILL.
- IDLE:
  - On START write at edge N, clear done and err, then compute ex1=min(X1,H_RES-1) and ey1=min(Y1,V_RES-1).
  - If X0>ex1 or Y0>ey1: stay IDLE, set err=1 and done=1, no pixel writes.
  - Otherwise latch X0, Y0, ex1, ey1, COLOR into working copies; set oX=X0, oY=Y0, oColor=COLOR, oWriteEn=1, oBusy=1; go to FILL.
  - First pixel is therefore visible in the cycle after the START edge (latency 1).
- FILL: each edge advances one pixel.
  - If oX<ex1: oX+1.
  - Else if oY<ey1: oX=X0 (latched), oY+1.
  - Else (last pixel just presented): oWriteEn=0, oBusy=0, done=1, go to IDLE.
  - Exactly (ex1-X0+1)*(ey1-Y0+1) cycles with oWriteEn=1; no gaps.
- START while in FILL is ignored. Register writes during FILL update the programmable registers but do not affect the active fill (working copies are used).
- ABORT in FILL: at that edge go to IDLE, oWriteEn=0, oBusy=0, done stays 0, err stays 0; the pixel presented in the ABORT cycle counts as written. ABORT in IDLE has no effect.
- A single-pixel rectangle (X0=X1, Y0=Y1) gives exactly one cycle of oWriteEn.
- oX and oY hold their last values after completion or abort.

Test Plan:
- Reset then read 0x14 -> 0x0; oWriteEn=0, oBusy=0.
- X0=10, Y0=20, X1=11, Y1=21, COLOR=0xE0, START -> 4 consecutive writes: (10,20), (11,20), (10,21), (11,21), all colour 0xE0; then busy=0, STATUS=0x2.
- X0=318, Y0=238, X1=400, Y1=255, START -> clipped to 318..319 x 238..239; 4 writes, none with x>319 or y>239; STATUS=0x2.
- X0=50, X1=40, START -> no oWriteEn pulses; STATUS=0x6 (err and done); a subsequent valid START clears err.
- Full-screen fill 0..319 x 0..239; at pixel 100 write START with new coordinates (ignored), then at pixel 200 write ABORT -> exactly 201 write cycles, STATUS=0x0.
- Reset asserted (iRST=0) asynchronously mid-fill -> oWriteEn and oBusy drop without waiting for a clock edge; after reset release no writes occur until the next START.

Source files
------------

// File: rtl/vga_rect_fill.sv
// Memory-mapped rectangle-fill engine: the CPU programs corners and a colour,
// then START streams one pixel write per clock in raster order to the VGA adapter.
module vga_rect_fill #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0200,
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemWrite,
  input  logic [31:0] iwMemAddress,
  input  logic [31:0] iwMemWriteData,
  output logic [31:0] oMemReadData,
  output logic [8:0]  oX,
  output logic [7:0]  oY,
  output logic [7:0]  oColor,
  output logic        oWriteEn,
  output logic        oBusy
);

  localparam logic [8:0] X_MAX = 9'(H_RES - 1);
  localparam logic [7:0] Y_MAX = 8'(V_RES - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_next;

  logic [8:0] x0_reg, x1_reg;
  logic [7:0] y0_reg, y1_reg, color_reg;

  logic [8:0] work_x0, work_x0_next;
  logic [8:0] work_x1, work_x1_next;
  logic [7:0] work_y1, work_y1_next;
  logic [8:0] pix_x, pix_x_next;
  logic [7:0] pix_y, pix_y_next;
  logic [7:0] pix_color, pix_color_next;
  logic       done, done_next;
  logic       err, err_next;

  logic [31:0] offset;
  logic        in_win;
  logic [2:0]  reg_sel;
  logic        wr_en;
  logic        ctrl_wr;
  logic        start_cmd;
  logic        abort_cmd;
  logic [8:0]  clip_x1;
  logic [7:0]  clip_y1;
  logic        bad_rect;
  logic        unused_bits;

  // The subtraction wraps, so addresses below BASE_ADDR land far outside the window.
  assign offset    = iwMemAddress - BASE_ADDR;
  assign in_win    = (offset < 32'h18) && (offset[1:0] == 2'b00);
  assign reg_sel   = offset[4:2];
  assign wr_en     = iMemWrite && in_win;
  assign ctrl_wr   = wr_en && (reg_sel == 3'd5);
  assign start_cmd = ctrl_wr && iwMemWriteData[0] && !iwMemWriteData[1];
  assign abort_cmd = ctrl_wr && iwMemWriteData[1];

  assign clip_x1  = (x1_reg > X_MAX) ? X_MAX : x1_reg;
  assign clip_y1  = (y1_reg > Y_MAX) ? Y_MAX : y1_reg;
  assign bad_rect = (x0_reg > clip_x1) || (y0_reg > clip_y1);

  assign unused_bits = ^iwMemWriteData[31:9];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x0_reg    <= '0;
      y0_reg    <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      color_reg <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        3'd0:    x0_reg    <= iwMemWriteData[8:0];
        3'd1:    y0_reg    <= iwMemWriteData[7:0];
        3'd2:    x1_reg    <= iwMemWriteData[8:0];
        3'd3:    y1_reg    <= iwMemWriteData[7:0];
        3'd4:    color_reg <= iwMemWriteData[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    oMemReadData = '0;
    if (in_win) begin
      case (reg_sel)
        3'd0:    oMemReadData = {23'b0, x0_reg};
        3'd1:    oMemReadData = {24'b0, y0_reg};
        3'd2:    oMemReadData = {23'b0, x1_reg};
        3'd3:    oMemReadData = {24'b0, y1_reg};
        3'd4:    oMemReadData = {24'b0, color_reg};
        3'd5:    oMemReadData = {29'b0, err, done, oBusy};
        default: oMemReadData = '0;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= IDLE;
      work_x0   <= '0;
      work_x1   <= '0;
      work_y1   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      work_x0   <= work_x0_next;
      work_x1   <= work_x1_next;
      work_y1   <= work_y1_next;
      pix_x     <= pix_x_next;
      pix_y     <= pix_y_next;
      pix_color <= pix_color_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

  // The fill runs from working copies so register writes mid-fill only affect the next START.
  always_comb begin
    state_next     = state;
    work_x0_next   = work_x0;
    work_x1_next   = work_x1;
    work_y1_next   = work_y1;
    pix_x_next     = pix_x;
    pix_y_next     = pix_y;
    pix_color_next = pix_color;
    done_next      = done;
    err_next       = err;
    case (state)
      IDLE: begin
        if (start_cmd) begin
          if (bad_rect) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else begin
            done_next      = 1'b0;
            err_next       = 1'b0;
            work_x0_next   = x0_reg;
            work_x1_next   = clip_x1;
            work_y1_next   = clip_y1;
            pix_x_next     = x0_reg;
            pix_y_next     = y0_reg;
            pix_color_next = color_reg;
            state_next     = FILL;
          end
        end
      end
      FILL: begin
        if (abort_cmd) begin
          state_next = IDLE;
        end else if (pix_x < work_x1) begin
          pix_x_next = pix_x + 9'd1;
        end else if (pix_y < work_y1) begin
          pix_x_next = work_x0;
          pix_y_next = pix_y + 8'd1;
        end else begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign oX       = pix_x;
  assign oY       = pix_y;
  assign oColor   = pix_color;
  assign oWriteEn = (state == FILL);
  assign oBusy    = (state == FILL);

endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomized self-checking bench for vga_rect_fill against a queue-based
// raster model of the expected pixel stream.
module tb_vga_rect_fill;

  localparam logic [31:0] BASE = 32'hFFFF0200;
  localparam int HRES = 320;
  localparam int VRES = 240;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iMemWrite;
  logic [31:0] iwMemAddress;
  logic [31:0] iwMemWriteData;
  logic [31:0] oMemReadData;
  logic [8:0]  oX;
  logic [7:0]  oY;
  logic [7:0]  oColor;
  logic        oWriteEn;
  logic        oBusy;

  int checkCount = 0;
  int failCount  = 0;
  int weCount    = 0;

  vga_rect_fill #(.BASE_ADDR(BASE), .H_RES(HRES), .V_RES(VRES)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iMemWrite(iMemWrite),
    .iwMemAddress(iwMemAddress),
    .iwMemWriteData(iwMemWriteData),
    .oMemReadData(oMemReadData),
    .oX(oX),
    .oY(oY),
    .oColor(oColor),
    .oWriteEn(oWriteEn),
    .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  // Running count of pixel-write cycles, used by the abort and reset scenarios.
  always @(negedge iCLK) if (oWriteEn) weCount <= weCount + 1;

  initial begin
    #5000000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic cpuWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge iCLK);
    iwMemAddress   = addr;
    iwMemWriteData = data;
    iMemWrite      = 1'b1;
    @(posedge iCLK);
    #1;
    iMemWrite = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    @(negedge iCLK);
    iMemWrite    = 1'b0;
    iwMemAddress = addr;
    #1;
    data = oMemReadData;
  endtask

  // Programs a rectangle, starts it, and compares every cycle of the stream to the model.
  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1, input logic [7:0] color);
    logic [31:0] expQ[$];
    logic [31:0] rd;
    int ex1, ey1;
    bit bad;
    cpuWrite(BASE + 32'h00, x0);
    cpuWrite(BASE + 32'h04, y0);
    cpuWrite(BASE + 32'h08, x1);
    cpuWrite(BASE + 32'h0C, y1);
    cpuWrite(BASE + 32'h10, {24'b0, color});
    readReg(BASE + 32'h08, rd);
    checkOutput("x1_readback", rd, 32'(x1 & 9'h1FF));
    ex1 = (x1 > HRES - 1) ? HRES - 1 : x1;
    ey1 = (y1 > VRES - 1) ? VRES - 1 : y1;
    bad = (x0 > ex1) || (y0 > ey1);
    if (!bad)
      for (int y = y0; y <= ey1; y++)
        for (int x = x0; x <= ex1; x++)
          expQ.push_back({6'b0, 1'b1, 9'(x), 8'(y), color});
    cpuWrite(BASE + 32'h14, 32'h1);
    foreach (expQ[i]) begin
      @(negedge iCLK);
      checkOutput("pixel", {6'b0, oWriteEn, oX, oY, oColor}, expQ[i]);
    end
    repeat (bad ? 3 : 1) begin
      @(negedge iCLK);
      checkOutput("idle_after", {30'b0, oWriteEn, oBusy}, 32'h0);
    end
    readReg(BASE + 32'h14, rd);
    checkOutput("status", rd, bad ? 32'h6 : 32'h2);
  endtask

  initial begin
    logic [31:0] rd;
    int x0, y0, x1, y1, base;
    iRST           = 1'b0;
    iMemWrite      = 1'b0;
    iwMemAddress   = '0;
    iwMemWriteData = '0;
    #12;
    checkOutput("reset_outputs", {5'b0, oWriteEn, oBusy, oX, oY, oColor}, 32'h0);
    @(negedge iCLK);
    iRST = 1'b1;
    readReg(BASE + 32'h14, rd);
    checkOutput("reset_status", rd, 32'h0);

    applyStimulus(10, 20, 11, 21, 8'hE0);
    applyStimulus(318, 238, 400, 255, 8'h1C);
    applyStimulus(50, 0, 40, 5, 8'h03);
    applyStimulus(7, 9, 7, 9, 8'hA5);

    readReg(BASE + 32'h18, rd);
    checkOutput("out_of_window_read", rd, 32'h0);
    cpuWrite(BASE + 32'h01, 32'h55);
    readReg(BASE + 32'h00, rd);
    checkOutput("unaligned_write_ignored", rd, 32'd7);

    for (int n = 0; n < 20; n++) begin
      x0 = $urandom_range(0, 330);
      x1 = x0 + $urandom_range(0, 14) - 2;
      if (x1 < 0) x1 = 0;
      if (x1 > 511) x1 = 511;
      y0 = $urandom_range(0, 245);
      y1 = y0 + $urandom_range(0, 10) - 2;
      if (y1 < 0) y1 = 0;
      if (y1 > 255) y1 = 255;
      applyStimulus(x0, y0, x1, y1, 8'($urandom));
    end

    // Full-screen fill with an ignored START midway and ABORT on pixel 200.
    cpuWrite(BASE + 32'h00, 0);
    cpuWrite(BASE + 32'h04, 0);
    cpuWrite(BASE + 32'h08, 319);
    cpuWrite(BASE + 32'h0C, 239);
    base = weCount;
    cpuWrite(BASE + 32'h14, 32'h1);
    repeat (100) @(posedge iCLK);
    cpuWrite(BASE + 32'h00, 7);
    cpuWrite(BASE + 32'h08, 8);
    cpuWrite(BASE + 32'h14, 32'h1);
    repeat (97) @(posedge iCLK);
    cpuWrite(BASE + 32'h14, 32'h2);
    @(negedge iCLK);
    checkOutput("abort_idle", {30'b0, oWriteEn, oBusy}, 32'h0);
    checkOutput("abort_write_count", 32'(weCount - base), 32'd201);
    checkOutput("abort_hold_xy", {15'b0, oX, oY}, {15'b0, 9'd200, 8'd0});
    readReg(BASE + 32'h14, rd);
    checkOutput("abort_status", rd, 32'h0);

    // Asynchronous reset in the middle of a fill.
    cpuWrite(BASE + 32'h08, 100);
    cpuWrite(BASE + 32'h0C, 100);
    cpuWrite(BASE + 32'h14, 32'h1);
    repeat (5) @(posedge iCLK);
    #2;
    checkOutput("busy_before_reset", {30'b0, oWriteEn, oBusy}, 32'h3);
    iRST = 1'b0;
    #1;
    checkOutput("async_reset_drop", {30'b0, oWriteEn, oBusy}, 32'h0);
    @(negedge iCLK);
    iRST = 1'b1;
    base = weCount;
    repeat (20) @(negedge iCLK);
    checkOutput("no_writes_after_reset", 32'(weCount - base), 32'd0);
    readReg(BASE + 32'h08, rd);
    checkOutput("reset_clears_x1", rd, 32'h0);
    readReg(BASE + 32'h14, rd);
    checkOutput("status_after_reset", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
